// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA layer priority arbiter.
//   rgb_t               8-bit RRRGGGBB pixel
//   cfg_state_e         priority-table commit state
//   DEFAULT_NUM_LAYERS  default number of object layers
package vga_arb_pkg;

  localparam int DEFAULT_NUM_LAYERS = 4;

  typedef logic [7:0] rgb_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/layer_priority_select.sv
// Combinational min-rank search over a set of layer requests.
//   req           per-layer request
//   rank          per-layer rank, 0 = top priority
//   winner_id     requesting layer with the lowest rank (0 when none)
//   winner_valid  1 when at least one layer requests
// Equal ranks resolve to the lower layer index: the scan runs upward and
// only a strictly better rank displaces the current candidate.
module layer_priority_select
  import vga_arb_pkg::*;
#(
  parameter int NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic [NUM_LAYERS-1:0]            req,
  input  logic [NUM_LAYERS-1:0][IDX_W-1:0] rank,
  output logic [IDX_W-1:0]                 winner_id,
  output logic                             winner_valid
);

  logic [IDX_W-1:0] best_rank;

  always_comb begin
    winner_id    = '0;
    winner_valid = 1'b0;
    best_rank    = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (req[i] && (!winner_valid || (rank[i] < best_rank))) begin
        winner_id    = IDX_W'(i);
        winner_valid = 1'b1;
        best_rank    = rank[i];
      end
    end
  end

endmodule

// File: rtl/layer_priority_arbiter.sv
// Programmable-priority pixel arbiter between NUM_LAYERS drawing objects and
// the background, with per-pixel and per-frame collision reporting.
//   clk, reset                 pixel clock, async active-high reset
//   layerRGB/DrawingRequest    per-layer colour and request
//   backGroundRGB              colour used when no layer requests
//   startOfFrame               first-pixel pulse; frame boundary for the
//                              collision summary and rank-table commit
//   cfgValid/Ready/Layer/Rank  shadow rank-table write port
//   cfgCommit                  copy shadow to active at next startOfFrame
//   rgbOut/winnerId/Valid      arbitrated pixel, 2-cycle latency
//   collision                  >=2 requests on this pixel
//   frameCollisions            layers that collided during the last frame
module layer_priority_arbiter
  import vga_arb_pkg::*;
#(
  parameter  int NUM_LAYERS = DEFAULT_NUM_LAYERS,
  parameter  int RGB_W      = 8,
  localparam int IDX_W      = $clog2(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
  input  logic [RGB_W-1:0]            backGroundRGB,
  input  logic                        startOfFrame,
  input  logic                        cfgValid,
  output logic                        cfgReady,
  input  logic [IDX_W-1:0]            cfgLayer,
  input  logic [IDX_W-1:0]            cfgRank,
  input  logic                        cfgCommit,
  output logic [RGB_W-1:0]            rgbOut,
  output logic [IDX_W-1:0]            winnerId,
  output logic                        winnerValid,
  output logic                        collision,
  output logic [NUM_LAYERS-1:0]       frameCollisions
);

  logic [NUM_LAYERS-1:0]             req_s1_q, req_s1_d;
  logic [NUM_LAYERS-1:0][RGB_W-1:0]  rgb_s1_q, rgb_s1_d;
  logic [RGB_W-1:0]                  bg_s1_q, bg_s1_d;
  logic [RGB_W-1:0]                  rgb_out_q, rgb_out_d;
  logic [IDX_W-1:0]                  winner_id_q, winner_id_d;
  logic                              winner_valid_q, winner_valid_d;
  logic                              collision_q, collision_d;
  logic [NUM_LAYERS-1:0]             frame_coll_q, frame_coll_d;
  logic [NUM_LAYERS-1:0]             acc_q, acc_d;
  cfg_state_e                        state_q, state_d;
  logic [NUM_LAYERS-1:0][IDX_W-1:0]  active_rank_q, active_rank_d;
  logic [NUM_LAYERS-1:0][IDX_W-1:0]  shadow_rank_q, shadow_rank_d;

  logic [IDX_W-1:0]      sel_id;
  logic                  sel_valid;
  logic                  s1_collision;
  logic [NUM_LAYERS-1:0] coll_contrib;

  // The S2 decision uses whatever table is active at that edge, so a commit
  // takes effect starting with the pixel presented alongside startOfFrame.
  layer_priority_select #(
    .NUM_LAYERS (NUM_LAYERS),
    .IDX_W      (IDX_W)
  ) u_select (
    .req          (req_s1_q),
    .rank         (active_rank_q),
    .winner_id    (sel_id),
    .winner_valid (sel_valid)
  );

  always_comb begin
    req_s1_d       = layerDrawingRequest;
    rgb_s1_d       = layerRGB;
    bg_s1_d        = backGroundRGB;
    s1_collision   = ($countones(req_s1_q) > 1);
    coll_contrib   = s1_collision ? req_s1_q : '0;
    rgb_out_d      = sel_valid ? rgb_s1_q[sel_id] : bg_s1_q;
    winner_id_d    = sel_id;
    winner_valid_d = sel_valid;
    collision_d    = s1_collision;
    frame_coll_d   = frame_coll_q;
    acc_d          = acc_q | coll_contrib;
    // The overlap seen on the boundary cycle belongs to the new frame.
    if (startOfFrame) begin
      frame_coll_d = acc_q;
      acc_d        = coll_contrib;
    end
  end

  always_comb begin
    state_d       = state_q;
    shadow_rank_d = shadow_rank_q;
    active_rank_d = active_rank_q;
    cfgReady      = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfgReady = 1'b1;
        if (cfgValid) begin
          // Matching by index drops cfgLayer values beyond the last layer.
          for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cfgLayer == IDX_W'(i)) shadow_rank_d[i] = cfgRank;
          end
        end
        if (cfgCommit) state_d = PENDING;
      end
      PENDING: begin
        if (startOfFrame) begin
          active_rank_d = shadow_rank_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_s1_q       <= '0;
      rgb_s1_q       <= '0;
      bg_s1_q        <= '0;
      rgb_out_q      <= '0;
      winner_id_q    <= '0;
      winner_valid_q <= 1'b0;
      collision_q    <= 1'b0;
      frame_coll_q   <= '0;
      acc_q          <= '0;
      state_q        <= IDLE;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        active_rank_q[i] <= IDX_W'(i);
        shadow_rank_q[i] <= IDX_W'(i);
      end
    end else begin
      req_s1_q       <= req_s1_d;
      rgb_s1_q       <= rgb_s1_d;
      bg_s1_q        <= bg_s1_d;
      rgb_out_q      <= rgb_out_d;
      winner_id_q    <= winner_id_d;
      winner_valid_q <= winner_valid_d;
      collision_q    <= collision_d;
      frame_coll_q   <= frame_coll_d;
      acc_q          <= acc_d;
      state_q        <= state_d;
      active_rank_q  <= active_rank_d;
      shadow_rank_q  <= shadow_rank_d;
    end
  end

  assign rgbOut          = rgb_out_q;
  assign winnerId        = winner_id_q;
  assign winnerValid     = winner_valid_q;
  assign collision       = collision_q;
  assign frameCollisions = frame_coll_q;

endmodule

// File: tb/tb_layer_priority_arbiter.sv
module tb_layer_priority_arbiter;
  import vga_arb_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*8-1:0] layerRGB;
  logic [N-1:0] layerDrawingRequest;
  logic [7:0]   backGroundRGB;
  logic         startOfFrame;
  logic         cfgValid;
  logic         cfgReady;
  logic [1:0]   cfgLayer;
  logic [1:0]   cfgRank;
  logic         cfgCommit;
  logic [7:0]   rgbOut;
  logic [1:0]   winnerId;
  logic         winnerValid;
  logic         collision;
  logic [N-1:0] frameCollisions;

  int n_checks = 0;
  int n_fail   = 0;

  layer_priority_arbiter #(.NUM_LAYERS(N), .RGB_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .layerRGB            (layerRGB),
    .layerDrawingRequest (layerDrawingRequest),
    .backGroundRGB       (backGroundRGB),
    .startOfFrame        (startOfFrame),
    .cfgValid            (cfgValid),
    .cfgReady            (cfgReady),
    .cfgLayer            (cfgLayer),
    .cfgRank             (cfgRank),
    .cfgCommit           (cfgCommit),
    .rgbOut              (rgbOut),
    .winnerId            (winnerId),
    .winnerValid         (winnerValid),
    .collision           (collision),
    .frameCollisions     (frameCollisions)
  );

  always #5 clk = ~clk;

  // Reference model: pixel held one cycle, then resolved by rank search.
  int         m_active[N];
  int         m_shadow[N];
  bit         m_pending;
  logic [N-1:0] m_acc, m_frame;
  logic [N-1:0] m_s1_req;
  logic [7:0] m_s1_rgb[N];
  logic [7:0] m_s1_bg;
  logic [7:0] e_rgb;
  logic [1:0] e_id;
  bit         e_valid, e_coll;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_active[i] = i;
      m_shadow[i] = i;
      m_s1_rgb[i] = 8'h00;
    end
    m_pending = 0; m_acc = '0; m_frame = '0;
    m_s1_req = '0; m_s1_bg = 8'h00;
    e_rgb = 8'h00; e_id = 2'd0; e_valid = 0; e_coll = 0;
  endtask

  // Best rank first, then lowest index among layers sharing that rank.
  function automatic void arb(input logic [N-1:0] req, output logic [1:0] id, output bit valid);
    id = 2'd0; valid = 0;
    for (int r = 0; r < N && !valid; r++)
      for (int i = 0; i < N && !valid; i++)
        if (req[i] && m_active[i] == r) begin
          id = 2'(i); valid = 1;
        end
  endfunction

  task automatic tick();
    logic [1:0] id;
    bit v;
    logic [N-1:0] contrib;
    @(posedge clk);
    if (!reset) begin
      arb(m_s1_req, id, v);
      e_valid = v;
      e_id    = v ? id : 2'd0;
      e_rgb   = v ? m_s1_rgb[id] : m_s1_bg;
      e_coll  = ($countones(m_s1_req) >= 2);
      contrib = e_coll ? m_s1_req : '0;
      if (startOfFrame) begin
        m_frame = m_acc;
        m_acc   = contrib;
      end else begin
        m_acc = m_acc | contrib;
      end
      if (!m_pending) begin
        if (cfgValid) m_shadow[cfgLayer] = int'(cfgRank);
        if (cfgCommit) m_pending = 1;
      end else if (startOfFrame) begin
        for (int i = 0; i < N; i++) m_active[i] = m_shadow[i];
        m_pending = 0;
      end
      m_s1_req = layerDrawingRequest;
      for (int i = 0; i < N; i++) m_s1_rgb[i] = layerRGB[i*8 +: 8];
      m_s1_bg = backGroundRGB;
    end
    #1;
  endtask

  task automatic drive_px(input logic [N-1:0] req, input logic [31:0] rgbs, input logic [7:0] bg);
    layerDrawingRequest = req;
    layerRGB            = rgbs;
    backGroundRGB       = bg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_px(4'b0000, 32'h0, 8'h00);
    startOfFrame = 0; cfgValid = 0; cfgLayer = 0; cfgRank = 0; cfgCommit = 0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    drive_px(4'b1111, 32'h44332211, 8'h77);
    tick(); tick();
    n_checks++;
    if (winnerId !== 2'd0 || rgbOut !== 8'h11 || winnerValid !== 1'b1) begin
      n_fail++; $display("FAIL reset_identity_tie got id=%0d rgb=%h v=%b exp id=0 rgb=11 v=1", winnerId, rgbOut, winnerValid);
    end
    startOfFrame = 1; tick(); startOfFrame = 0; tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    n_checks++;
    if (frameCollisions !== 4'hF) begin
      n_fail++; $display("FAIL reset_prefill_frame got %b exp 1111", frameCollisions);
    end
    cfgCommit = 1; tick(); cfgCommit = 0;
    n_checks++;
    if (cfgReady !== 1'b0) begin
      n_fail++; $display("FAIL reset_prefill_pending got ready=%b exp 0", cfgReady);
    end
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (rgbOut !== 8'h00 || winnerId !== 2'd0 || winnerValid !== 1'b0 || collision !== 1'b0
        || frameCollisions !== 4'h0 || cfgReady !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_async got rgb=%h id=%0d v=%b c=%b fc=%b rdy=%b exp all 0 rdy=1",
               rgbOut, winnerId, winnerValid, collision, frameCollisions, cfgReady);
    end
    tick(); tick();
    reset = 1'b0;
    startOfFrame = 1; tick(); startOfFrame = 0; tick();
    n_checks++;
    if (cfgReady !== 1'b1 || winnerId !== 2'd0 || rgbOut !== 8'h11) begin
      n_fail++; $display("FAIL reset_discard_commit got rdy=%b id=%0d rgb=%h exp rdy=1 id=0 rgb=11", cfgReady, winnerId, rgbOut);
    end
  endtask

  task automatic test_default_priority();
    drive_px(4'b0110, 32'h551CE033, 8'h03);
    tick();
    drive_px(4'b0000, 32'h551CE033, 8'h55);
    tick();
    n_checks++;
    if (rgbOut !== 8'hE0 || winnerId !== 2'd1 || winnerValid !== 1'b1 || collision !== 1'b1) begin
      n_fail++; $display("FAIL default_pri got rgb=%h id=%0d v=%b c=%b exp E0 1 1 1", rgbOut, winnerId, winnerValid, collision);
    end
    tick();
    n_checks++;
    if (rgbOut !== 8'h55 || winnerId !== 2'd0 || winnerValid !== 1'b0 || collision !== 1'b0) begin
      n_fail++; $display("FAIL default_bg got rgb=%h id=%0d v=%b c=%b exp 55 0 0 0", rgbOut, winnerId, winnerValid, collision);
    end
  endtask

  task automatic test_reprogram();
    drive_px(4'b0110, 32'h551CE033, 8'h03);
    cfgValid = 1; cfgLayer = 2; cfgRank = 0;
    tick();
    cfgLayer = 1; cfgRank = 1; cfgCommit = 1;
    tick();
    cfgValid = 0; cfgCommit = 0;
    n_checks++;
    if (cfgReady !== 1'b0) begin
      n_fail++; $display("FAIL reprog_ready_low got %b exp 0", cfgReady);
    end
    tick(); tick();
    n_checks++;
    if (rgbOut !== 8'hE0 || winnerId !== 2'd1) begin
      n_fail++; $display("FAIL reprog_before_sof got rgb=%h id=%0d exp E0 1", rgbOut, winnerId);
    end
    startOfFrame = 1; tick(); startOfFrame = 0;
    n_checks++;
    if (rgbOut !== 8'hE0 || cfgReady !== 1'b1) begin
      n_fail++; $display("FAIL reprog_at_sof got rgb=%h rdy=%b exp E0 1", rgbOut, cfgReady);
    end
    tick();
    n_checks++;
    if (rgbOut !== 8'h1C || winnerId !== 2'd2) begin
      n_fail++; $display("FAIL reprog_applied got rgb=%h id=%0d exp 1C 2", rgbOut, winnerId);
    end
  endtask

  task automatic test_commit_on_sof();
    cfgValid = 1; cfgLayer = 1; cfgRank = 0; cfgCommit = 1; startOfFrame = 1;
    tick();
    cfgValid = 0; cfgCommit = 0; startOfFrame = 0;
    tick(); tick();
    n_checks++;
    if (rgbOut !== 8'h1C || winnerId !== 2'd2 || cfgReady !== 1'b0) begin
      n_fail++; $display("FAIL coinc_unchanged got rgb=%h id=%0d rdy=%b exp 1C 2 0", rgbOut, winnerId, cfgReady);
    end
    startOfFrame = 1; tick(); startOfFrame = 0;
    tick();
    n_checks++;
    if (rgbOut !== 8'hE0 || winnerId !== 2'd1 || cfgReady !== 1'b1) begin
      n_fail++; $display("FAIL coinc_next_frame got rgb=%h id=%0d rdy=%b exp E0 1 1", rgbOut, winnerId, cfgReady);
    end
  endtask

  task automatic test_collisions();
    drive_px(4'b0000, 32'h0, 8'h00);
    tick(); tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    drive_px(4'b1001, 32'h0, 8'h00); tick();
    drive_px(4'b1000, 32'h0, 8'h00); tick();
    drive_px(4'b0001, 32'h0, 8'h00); tick();
    drive_px(4'b0000, 32'h0, 8'h00); tick(); tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    n_checks++;
    if (frameCollisions !== 4'b1001) begin
      n_fail++; $display("FAIL coll_frame_03 got %b exp 1001", frameCollisions);
    end
    drive_px(4'b0100, 32'h0, 8'h00); tick(); tick(); tick();
    drive_px(4'b0110, 32'h0, 8'h00); tick();
    drive_px(4'b0000, 32'h0, 8'h00); startOfFrame = 1; tick(); startOfFrame = 0;
    n_checks++;
    if (frameCollisions !== 4'b0000) begin
      n_fail++; $display("FAIL coll_clean_frame got %b exp 0000", frameCollisions);
    end
    tick(); tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    n_checks++;
    if (frameCollisions !== 4'b0110) begin
      n_fail++; $display("FAIL coll_on_sof_new_frame got %b exp 0110", frameCollisions);
    end
  endtask

  task automatic test_tie_and_random();
    logic [1:0] exp_rdy;
    cfgValid = 1; cfgLayer = 1; cfgRank = 0; tick();
    cfgLayer = 3; cfgRank = 0; cfgCommit = 1; tick();
    cfgValid = 0; cfgCommit = 0; tick();
    startOfFrame = 1; tick(); startOfFrame = 0;
    drive_px(4'b1010, 32'hAA00BB00, 8'h01);
    tick(); tick();
    n_checks++;
    if (winnerId !== 2'd1 || rgbOut !== 8'hBB) begin
      n_fail++; $display("FAIL tie_1_3 got id=%0d rgb=%h exp 1 BB", winnerId, rgbOut);
    end
    for (int px = 0; px < 10000; px++) begin
      drive_px(4'($urandom), $urandom, 8'($urandom));
      startOfFrame = ($urandom_range(0, 49) == 0);
      cfgValid     = ($urandom_range(0, 7) == 0);
      cfgLayer     = 2'($urandom);
      cfgRank      = 2'($urandom);
      cfgCommit    = ($urandom_range(0, 31) == 0);
      tick();
      exp_rdy = m_pending ? 2'd0 : 2'd1;
      n_checks++;
      if (rgbOut !== e_rgb || winnerId !== e_id || winnerValid !== e_valid || collision !== e_coll
          || frameCollisions !== m_frame || cfgReady !== exp_rdy[0]) begin
        n_fail++;
        $display("FAIL rand px=%0d got rgb=%h id=%0d v=%b c=%b fc=%b rdy=%b exp rgb=%h id=%0d v=%b c=%b fc=%b rdy=%b",
                 px, rgbOut, winnerId, winnerValid, collision, frameCollisions, cfgReady,
                 e_rgb, e_id, e_valid, e_coll, m_frame, exp_rdy[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_priority();
    test_reprogram();
    test_commit_on_sof();
    test_collisions();
    test_tie_and_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
